// File: rtl/moving_sum_len_ctrl.sv
// Run-time window-length controller for the moving-sum datapath.
// Applies new lengths at packet boundaries once the sum output has drained.
module moving_sum_len_ctrl #(
    parameter int          MAX_LEN_LOG2 = 10,
    parameter int          WIDTH        = 16,
    parameter logic [7:0]  SR_LEN       = 8'd0,
    parameter int          DEFAULT_LEN  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    input  logic             ms_o_tvalid,
    output logic [15:0]      ms_len,
    output logic             ms_clear,
    output logic             busy,
    output logic             len_err,
    output logic             window_full
);

    localparam int          CW      = MAX_LEN_LOG2 + 1;
    localparam logic [15:0] MAX_LEN = 16'(1 << MAX_LEN_LOG2);
    localparam logic [15:0] DEF_LEN = 16'(DEFAULT_LEN);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [15:0]   pend_len_q, pend_len_d;
    logic [15:0]   ms_len_q, ms_len_d;
    logic          len_err_q, len_err_d;
    logic          in_pkt_q, in_pkt_d;
    logic [CW-1:0] count_q, count_d;

    logic          wr;
    logic [15:0]   req;
    logic          gate;
    logic          acc;
    logic          unused_set_hi;

    assign wr            = set_stb & (set_addr == SR_LEN);
    assign req           = set_data[15:0];
    assign unused_set_hi = ^set_data[31:16];

    // Close the gate only between packets so a packet is never split.
    assign gate     = (state_q == ST_RUN) & ~(pending_q & ~in_pkt_q);
    assign s_tready = m_tready & gate & ~reset;
    assign m_tvalid = s_tvalid & gate & ~reset;
    assign m_tdata  = s_tdata;
    assign m_tlast  = s_tlast;
    assign acc      = s_tvalid & s_tready;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pend_len_d = pend_len_q;
        ms_len_d   = ms_len_q;
        len_err_d  = len_err_q;
        in_pkt_d   = in_pkt_q;
        count_d    = count_q;

        if (wr) begin
            pending_d = 1'b1;
            if (req == 16'd0) begin
                pend_len_d = 16'd1;
                len_err_d  = 1'b1;
            end else if (req > MAX_LEN) begin
                pend_len_d = MAX_LEN;
                len_err_d  = 1'b1;
            end else begin
                pend_len_d = req;
                len_err_d  = 1'b0;
            end
        end

        if (acc) begin
            in_pkt_d = ~s_tlast;
            if (16'(count_q) < ms_len_q) begin
                count_d = count_q + CW'(1);
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (pending_q & ~in_pkt_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!ms_o_tvalid) begin
                    state_d   = ST_CLEAR;
                    ms_len_d  = pend_len_q;
                    pending_d = wr;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
                count_d = '0;
            end
            default: state_d = ST_RUN;
        endcase

        // Soft clear overrides any write or transition in the same cycle.
        if (clear) begin
            state_d    = ST_RUN;
            pending_d  = 1'b0;
            in_pkt_d   = 1'b0;
            count_d    = '0;
            pend_len_d = pend_len_q;
            len_err_d  = len_err_q;
            ms_len_d   = ms_len_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pending_q  <= 1'b0;
            pend_len_q <= DEF_LEN;
            ms_len_q   <= DEF_LEN;
            len_err_q  <= 1'b0;
            in_pkt_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_len_q <= pend_len_d;
            ms_len_q   <= ms_len_d;
            len_err_q  <= len_err_d;
            in_pkt_q   <= in_pkt_d;
            count_q    <= count_d;
        end
    end

    assign ms_len      = ms_len_q;
    assign ms_clear    = (state_q == ST_CLEAR) | clear;
    assign busy        = pending_q | (state_q != ST_RUN);
    assign len_err     = len_err_q;
    assign window_full = (16'(count_q) == ms_len_q);

endmodule

// File: tb/tb_moving_sum_len_ctrl.sv
// Scoreboard bench for moving_sum_len_ctrl: beats and applied lengths
// are queued at stimulus time and compared when the DUT emits them.
module tb_moving_sum_len_ctrl;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] s_tdata, m_tdata;
    logic        s_tlast, s_tvalid, s_tready;
    logic        m_tlast, m_tvalid, m_tready;
    logic        ms_o_tvalid, ms_clear, busy, len_err, window_full;
    logic [15:0] ms_len;

    int checks = 0;
    int failures = 0;
    int clr_cnt = 0;
    logic [16:0] exp_q[$];
    logic [15:0] len_q[$];
    logic [16:0] mon_e;

    moving_sum_len_ctrl dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .ms_o_tvalid(ms_o_tvalid), .ms_len(ms_len), .ms_clear(ms_clear),
        .busy(busy), .len_err(len_err), .window_full(window_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_len(input logic [31:0] d);
        logic [15:0] r;
        r = d[15:0];
        if (r == 16'd0) return 16'd1;
        if (r > 16'd1024) return 16'd1024;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("beat_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat", 32'({m_tlast, m_tdata}), 32'(mon_e));
            end
        end
        if (!reset && ms_clear && !clear) begin
            clr_cnt++;
            if (len_q.size() == 0)
                chk("clr_extra", 32'(len_q.size()), 32'd1);
            else
                chk("clr_len", 32'(ms_len), 32'(len_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_len(input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = 8'd0;
        set_data = d;
        len_q.push_back(exp_len(d));
        tick();
        set_stb = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        exp_q.push_back({last, d});
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_tready;
            n++;
        end
        chk("send_acc", 32'(acc), 32'd1);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_clr(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ms_clear && k < 50);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int k, c0;
        logic [31:0] cl_d[3];
        logic        cl_e[3];
        cl_d = '{32'd0, 32'd2000, 32'd5};
        cl_e = '{1'b1, 1'b1, 1'b0};

        reset = 1'b1; clear = 1'b0; set_stb = 1'b0;
        set_addr = 8'd0; set_data = '0;
        s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b1;
        m_tready = 1'b1; ms_o_tvalid = 1'b0;
        #1;
        chk("rst_ms_len", 32'(ms_len), 32'd16);
        chk("rst_ms_clear", 32'(ms_clear), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_wfull", 32'(window_full), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        s_tvalid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("tready_after_rst", 32'(s_tready), 32'd1);

        // idle length change
        wr_len(32'd8);
        chk("idle_busy", 32'(busy), 32'd1);
        chk("idle_gate", 32'(s_tready), 32'd0);
        wait_clr(k);
        chk("idle_lat", 32'(k), 32'd3);
        tick();
        chk("idle_pulse1", 32'(ms_clear), 32'd0);
        chk("idle_busy_off", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send(16'(100 + i), i == 7);
            if (i == 6) chk("wf_7", 32'(window_full), 32'd0);
        end
        chk("wf_8", 32'(window_full), 32'd1);

        // write mid-packet
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                set_stb = 1'b1;
                set_data = 32'd4;
                len_q.push_back(16'd4);
            end
            send(16'(200 + i), i == 9);
            set_stb = 1'b0;
        end
        chk("mid_tready_drop", 32'(s_tready), 32'd0);
        chk("mid_all_beats", 32'(exp_q.size()), 32'd0);
        wait_clr(k);
        chk("mid_lat", 32'(k), 32'd3);
        tick();
        send(16'd300, 1'b0);
        send(16'd301, 1'b1);
        chk("mid_next_pkt", 32'(exp_q.size()), 32'd0);

        // drain stall
        ms_o_tvalid = 1'b1;
        wr_len(32'd12);
        c0 = 0;
        repeat (22) begin
            @(negedge clk);
            if (ms_clear || s_tready) c0++;
        end
        chk("drain_hold", 32'(c0), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        tick();
        ms_o_tvalid = 1'b0;
        wait_clr(k);
        chk("drain_exit", 32'(k), 32'd2);
        tick();

        // range clamp
        for (int i = 0; i < 3; i++) begin
            wr_len(cl_d[i]);
            chk("len_err", 32'(len_err), 32'(cl_e[i]));
            wait_clr(k);
            chk("clamp_lat", 32'(k), 32'd3);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            send(16'(400 + i), i == 4);
            if (i == 3) chk("wf5_4", 32'(window_full), 32'd0);
        end
        chk("wf5_5", 32'(window_full), 32'd1);
        send(16'd410, 1'b1);
        chk("wf5_sat", 32'(window_full), 32'd1);

        // write during CLEAR
        c0 = clr_cnt;
        wr_len(32'd7);
        wait_clr(k);
        set_stb = 1'b1;
        set_data = 32'd9;
        len_q.push_back(16'd9);
        tick();
        set_stb = 1'b0;
        wait_clr(k);
        chk("coll_lat", 32'(k), 32'd3);
        tick();
        chk("coll_pulses", 32'(clr_cnt - c0), 32'd2);

        // soft clear with simultaneous write
        for (int i = 0; i < 3; i++) send(16'(500 + i), i == 2);
        clear = 1'b1;
        set_stb = 1'b1;
        set_data = 32'd3;
        @(negedge clk);
        chk("soft_ms_clear", 32'(ms_clear), 32'd1);
        tick();
        clear = 1'b0;
        set_stb = 1'b0;
        chk("soft_len_kept", 32'(ms_len), 32'd9);
        chk("soft_busy", 32'(busy), 32'd0);
        chk("soft_wfull", 32'(window_full), 32'd0);
        c0 = clr_cnt;
        repeat (5) tick();
        chk("soft_no_change", 32'(clr_cnt - c0), 32'd0);
        for (int i = 0; i < 9; i++) begin
            send(16'(600 + i), i == 8);
            if (i == 7) chk("soft_cnt_zero", 32'(window_full), 32'd0);
        end
        chk("soft_wf9", 32'(window_full), 32'd1);

        // async reset mid-change
        wr_len(32'd20);
        wait_clr(k);
        #2;
        reset = 1'b1;
        s_tvalid = 1'b1;
        #1;
        chk("arst_ms_len", 32'(ms_len), 32'd16);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ms_clear", 32'(ms_clear), 32'd0);
        chk("arst_s_tready", 32'(s_tready), 32'd0);
        chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        s_tvalid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        c0 = clr_cnt;
        repeat (6) tick();
        chk("arst_no_clear", 32'(clr_cnt - c0), 32'd0);
        chk("arst_len_hold", 32'(ms_len), 32'd16);
        chk("arst_idle", 32'(busy), 32'd0);
        chk("len_q_empty", 32'(len_q.size()), 32'd0);
        chk("beat_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
